rd_frame_deframer: RTL and testbench
====================================

# rd_frame_deframer

Read-clock-domain consumer of the dual-clock async FIFO's read port. It pops bytes from the FIFO and parses a simple framing protocol: sync byte, length, payload, checksum. Payload bytes go out on a registered valid/ready byte stream with start/end markers, and the block reports per-frame checksum status. It sits directly downstream of the FIFO, and its pop strobe drives the FIFO's read-increment input.

## Interface
Parameters:
- SYNC, 8'hA5, frame sync byte
- DW, 8, data width (must match FIFO data width; only 8 supported)

Ports:
- rclk  in  1  read-domain clock (same clock as FIFO read side)
- rrst_n  in  1  asynchronous, active-low reset (same reset as FIFO read side)
- f_rdata  in  8  FIFO read data; valid whenever f_rempty=0
- f_rempty  in  1  FIFO empty flag
- f_rinc  out  1  FIFO pop strobe, combinational
- m_data  out  8  payload byte, registered
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_sop  out  1  qualifies m_data as first payload byte of the frame
- m_eop  out  1  qualifies m_data as last payload byte of the frame
- frame_ok  out  1  one-cycle pulse: checksum matched
- frame_err  out  1  one-cycle pulse: checksum mismatch or LEN=0
- err_cnt  out  8  saturating count of frame_err pulses

## Operation
- Frame on the wire: SYNC, LEN (1..255), LEN payload bytes, CSUM.
- Frame is good when (LEN + sum(payload) + CSUM) mod 256 == 0.
- Accumulator acc is 8 bits wide and wraps modulo 256.
- FSM states: HUNT, LEN, PAYLOAD, CSUM.
- HUNT: pop every byte. If the byte equals SYNC, go to LEN. Otherwise discard it and stay in HUNT.
- LEN: pop the byte.
  - LEN=0: pulse frame_err, go to HUNT.
  - LEN≠0: set remaining counter rem=LEN, set acc=LEN, set sop_pending=1, go to PAYLOAD.
- PAYLOAD: pop only when the output register is free (m_valid=0 or m_ready=1). On each pop:
  - load m_data; set m_valid=1.
  - m_sop=sop_pending, then clear sop_pending.
  - m_eop=(rem==1).
  - acc+=byte; rem-=1.
  - If rem==1 at the pop, go to CSUM.
- CSUM: pop the byte, compare (acc+byte)[7:0] with 0.
  - Match: pulse frame_ok. Mismatch: pulse frame_err.
  - Go to HUNT.
  - CSUM is not gated by m_ready; the last payload byte may still be waiting in the output register.
- SYNC-valued bytes inside LEN, PAYLOAD or CSUM are treated as data, not resync.
- err_cnt increments on every frame_err and saturates at 8'hFF.

## Timing
- f_rinc = ~f_rempty & pop_en.
  - pop_en=1 in HUNT, LEN and CSUM.
  - pop_en=(~m_valid | m_ready) in PAYLOAD.
- f_rinc is never asserted while f_rempty=1.
- f_rdata is sampled on the same rclk edge on which f_rinc=1; the FIFO advances on that edge.
- Latency: a payload byte popped at edge k appears on m_data/m_valid after edge k.
- With m_ready held at 1, one byte per cycle is sustained (back-to-back accept and reload).
- Output handshake:
  - m_valid deasserts on an edge where m_ready=1 and no pop occurs.
  - m_data, m_sop and m_eop stay stable while m_valid=1 and m_ready=0.
- frame_ok/frame_err are high for exactly the one cycle after the CSUM pop edge.
- Reset values:
  - state=HUNT.
  - m_data=0, m_valid=0, m_sop=0, m_eop=0.
  - frame_ok=0, frame_err=0, err_cnt=0.
  - rem=0, acc=0, sop_pending=0.
- Reset mid-frame discards the partial frame and drops any pending output byte. The FIFO read side resets with the same rrst_n, so both sides restart empty.
- FIFO empty mid-frame: the FSM holds its state and counters with no timeout, and resumes when f_rempty falls.
- LEN=1: that single byte carries m_sop=1 and m_eop=1.

## Test plan
- Good frame: FIFO holds A5 03 11 22 33 97, m_ready=1 -> m_data 11(sop), 22, 33(eop) on consecutive cycles; frame_ok pulses once; err_cnt=0.
- Bad checksum: A5 03 11 22 33 98 -> same three payload bytes; frame_err pulses once; err_cnt=1.
- Garbage then resync: 00 FF A5 01 5A A5 -> 00 and FF dropped; single byte 5A with sop=eop=1; frame_ok pulses (01+5A+A5=0x100).
- Backpressure: good frame with m_ready=0 for 5 cycles after the first byte -> m_data holds 11; f_rinc=0 during the stall; no byte lost or duplicated; order 11, 22, 33.
- LEN=0 and empty gaps: A5 00, then a good frame written with FIFO-empty gaps between bytes -> frame_err for LEN=0; f_rinc never high while f_rempty=1; second frame gives frame_ok.
- Reset mid-frame: assert rrst_n low after popping A5 03 11 -> all outputs return to reset values; after release, a new good frame parses correctly.

Source files
------------

// File: rtl/rd_frame_deframer.sv
// rd_frame_deframer: pops SYNC/LEN/payload/CSUM frames from the async FIFO read port and streams payload bytes out
module rd_frame_deframer #(
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int DW = 8
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic [DW-1:0] f_rdata,
  input  logic          f_rempty,
  output logic          f_rinc,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sop,
  output logic          m_eop,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
  state_t        state;
  logic [DW-1:0] rem, acc, sum;
  logic          sop_pending, pop_en, err_set;
  // payload pops wait for a free output register; every other state always consumes
  assign pop_en  = (state != PAYLOAD) | ~m_valid | m_ready;
  assign f_rinc  = ~f_rempty & pop_en;
  assign sum     = acc + f_rdata;
  assign err_set = f_rinc & (((state == LEN) & (f_rdata == '0)) | ((state == CSUM) & (sum != '0)));
  // frame parser, output register and status pulses
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= HUNT;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_sop       <= 1'b0;
      m_eop       <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      rem         <= '0;
      acc         <= '0;
      sop_pending <= 1'b0;
    end else begin
      frame_ok  <= f_rinc & (state == CSUM) & (sum == '0);
      frame_err <= err_set;
      if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (m_ready) m_valid <= 1'b0;
      if (f_rinc) begin
        case (state)
          HUNT: if (f_rdata == SYNC) state <= LEN;
          LEN: begin
            if (f_rdata == '0) state <= HUNT;
            else begin
              rem         <= f_rdata;
              acc         <= f_rdata;
              sop_pending <= 1'b1;
              state       <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            m_data      <= f_rdata;
            m_valid     <= 1'b1;
            m_sop       <= sop_pending;
            sop_pending <= 1'b0;
            m_eop       <= rem == 8'd1;
            acc         <= sum;
            rem         <= rem - 8'd1;
            if (rem == 8'd1) state <= CSUM;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rd_frame_deframer.sv
// tb_rd_frame_deframer: table-driven frames through a queue-modelled FIFO plus backpressure, gap, saturation and reset sequences
module tb_rd_frame_deframer;
  logic       rclk, rrst_n, f_rempty, f_rinc, m_valid, m_ready, m_sop, m_eop, frame_ok, frame_err;
  logic [7:0] f_rdata, m_data, err_cnt;
  rd_frame_deframer dut (
    .rclk(rclk), .rrst_n(rrst_n), .f_rdata(f_rdata), .f_rempty(f_rempty), .f_rinc(f_rinc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;
  typedef struct {
    logic [63:0] b;
    int          nb;
    logic [31:0] e;
    int          ne;
    int          ok;
    int          err;
  } vec_t;
  vec_t       v[6];
  logic [7:0] q[$];
  logic [9:0] out_q[$];
  int         out_t[$];
  int         n_vec, miss, viol, pops, cyc_n, ok_n, er_n, exp_errs, p0;
  bit         pop_now, gap;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive();
    f_rempty = (q.size() == 0) || (gap && cyc_n[0]);
    f_rdata  = (q.size() != 0) ? q[0] : 8'h00;
  endtask
  task automatic tick();
    drive();
    #1;
    pop_now = f_rinc;
    if (f_rinc && f_rempty) viol++;
    if (m_valid && m_ready) begin
      out_q.push_back({m_data, m_sop, m_eop});
      out_t.push_back(cyc_n);
    end
    @(posedge rclk);
    #1;
    cyc_n++;
    if (pop_now) begin
      void'(q.pop_front());
      pops++;
    end
    drive();
    ok_n += int'(frame_ok);
    er_n += int'(frame_err);
  endtask
  task automatic push_bytes(logic [63:0] b, int n);
    for (int j = 0; j < n; j++) q.push_back(b[63-8*j -: 8]);
  endtask
  task automatic clr();
    out_q.delete();
    out_t.delete();
    ok_n = 0;
    er_n = 0;
  endtask
  task automatic chk_out(string nm, logic [31:0] e, int ne);
    logic [9:0] ex, act;
    chk({nm, "_count"}, out_q.size(), ne);
    for (int j = 0; j < ne; j++) begin
      ex  = {e[31-8*j -: 8], j == 0, j == ne - 1};
      act = (j < out_q.size()) ? out_q[j] : 10'h3FF;
      chk($sformatf("%s_byte%0d", nm, j), act, ex);
    end
  endtask
  initial begin
    n_vec = 0; miss = 0; viol = 0; pops = 0; cyc_n = 0; exp_errs = 0;
    pop_now = 0; gap = 0; rrst_n = 1'b0; m_ready = 1'b1;
    v[0] = '{64'hA503112233970000, 6, 32'h11223300, 3, 1, 0};
    v[1] = '{64'hA503112233980000, 6, 32'h11223300, 3, 0, 1};
    v[2] = '{64'h00FFA5015AA50000, 6, 32'h5A000000, 1, 1, 0};
    v[3] = '{64'hA500000000000000, 2, 32'h00000000, 0, 0, 1};
    v[4] = '{64'hA502A5A5B4000000, 5, 32'hA5A50000, 2, 1, 0};
    v[5] = '{64'hA50100FF00000000, 4, 32'h00000000, 1, 1, 0};
    repeat (2) tick();
    chk("rst_outputs", {m_data, m_valid, m_sop, m_eop, frame_ok, frame_err, err_cnt}, 0);
    rrst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      clr();
      push_bytes(v[i].b, v[i].nb);
      repeat (v[i].nb + 6) tick();
      exp_errs += v[i].err;
      chk_out($sformatf("vec%0d", i), v[i].e, v[i].ne);
      chk($sformatf("vec%0d_ok", i), ok_n, v[i].ok);
      chk($sformatf("vec%0d_err", i), er_n, v[i].err);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, exp_errs);
      if (v[i].ne > 1 && out_t.size() == v[i].ne)
        chk($sformatf("vec%0d_b2b", i), out_t[v[i].ne-1] - out_t[0], v[i].ne - 1);
    end
    clr();
    m_ready = 1'b0;
    push_bytes(64'hA503112233970000, 6);
    for (int i = 0; i < 20 && !m_valid; i++) tick();
    chk("bp_first", {m_valid, m_data, m_sop, m_eop}, {1'b1, 8'h11, 1'b1, 1'b0});
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {m_valid, m_data, m_sop, m_eop}, {1'b1, 8'h11, 1'b1, 1'b0});
    end
    chk("bp_no_pop", pops - p0, 0);
    m_ready = 1'b1;
    repeat (10) tick();
    chk_out("bp", 32'h11223300, 3);
    chk("bp_ok", ok_n, 1);
    clr();
    gap = 1;
    push_bytes(64'hA500000000000000, 2);
    push_bytes(64'hA503112233970000, 6);
    repeat (30) tick();
    gap = 0;
    exp_errs++;
    chk_out("gap", 32'h11223300, 3);
    chk("gap_ok", ok_n, 1);
    chk("gap_err", er_n, 1);
    chk("gap_err_cnt", err_cnt, exp_errs);
    chk("no_pop_when_empty", viol, 0);
    for (int i = 0; i < 260; i++) push_bytes(64'hA500000000000000, 2);
    for (int i = 0; i < 600 && q.size() != 0; i++) tick();
    repeat (2) tick();
    chk("err_cnt_sat", err_cnt, 8'hFF);
    clr();
    m_ready = 1'b0;
    push_bytes(64'hA503112233970000, 6);
    p0 = pops;
    for (int i = 0; i < 20 && pops - p0 < 3; i++) tick();
    chk("rst_mid_pops", pops - p0, 3);
    chk("rst_mid_pending", {m_valid, m_data}, {1'b1, 8'h11});
    rrst_n = 1'b0;
    q.delete();
    pop_now = 0;
    #1;
    chk("rst_mid_outputs", {m_data, m_valid, m_sop, m_eop, frame_ok, frame_err, err_cnt}, 0);
    repeat (2) tick();
    rrst_n = 1'b1;
    clr();
    m_ready = 1'b1;
    push_bytes(64'hA503112233970000, 6);
    repeat (12) tick();
    chk_out("post_rst", 32'h11223300, 3);
    chk("post_rst_ok", ok_n, 1);
    chk("post_rst_err_cnt", err_cnt, 0);
    chk("no_pop_when_empty_final", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end
endmodule
